// File: rtl/axi_sram_responder.sv
// AXI4 subordinate that terminates a manager port into an on-chip word array.
// Independent read and write engines, one outstanding burst each, FIXED/INCR/WRAP bursts.
module axi_sram_responder #(
  parameter int unsigned   AW       = 64,
  parameter int unsigned   DW       = 64,
  parameter int unsigned   IW       = 8,
  parameter int unsigned   UW       = 1,
  parameter int unsigned   SW       = DW / 8,
  parameter int unsigned   NumWords = 1024,
  parameter logic [AW-1:0] BaseAddr = '0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [IW-1:0] ar_id_i,
  input  logic [AW-1:0] ar_addr_i,
  input  logic [7:0]    ar_len_i,
  input  logic [2:0]    ar_size_i,
  input  logic [1:0]    ar_burst_i,
  input  logic          ar_lock_i,
  input  logic [3:0]    ar_cache_i,
  input  logic [2:0]    ar_prot_i,
  input  logic [3:0]    ar_qos_i,
  input  logic [3:0]    ar_region_i,
  input  logic [UW-1:0] ar_user_i,
  input  logic          ar_valid_i,
  output logic          ar_ready_o,
  input  logic [IW-1:0] aw_id_i,
  input  logic [AW-1:0] aw_addr_i,
  input  logic [7:0]    aw_len_i,
  input  logic [2:0]    aw_size_i,
  input  logic [1:0]    aw_burst_i,
  input  logic          aw_lock_i,
  input  logic [3:0]    aw_cache_i,
  input  logic [2:0]    aw_prot_i,
  input  logic [3:0]    aw_qos_i,
  input  logic [3:0]    aw_region_i,
  input  logic [5:0]    aw_atop_i,
  input  logic [UW-1:0] aw_user_i,
  input  logic          aw_valid_i,
  output logic          aw_ready_o,
  input  logic [DW-1:0] w_data_i,
  input  logic [SW-1:0] w_strb_i,
  input  logic          w_last_i,
  input  logic [UW-1:0] w_user_i,
  input  logic          w_valid_i,
  output logic          w_ready_o,
  output logic [IW-1:0] b_id_o,
  output logic [1:0]    b_resp_o,
  output logic [UW-1:0] b_user_o,
  output logic          b_valid_o,
  input  logic          b_ready_i,
  output logic [IW-1:0] r_id_o,
  output logic [DW-1:0] r_data_o,
  output logic [1:0]    r_resp_o,
  output logic          r_last_o,
  output logic [UW-1:0] r_user_o,
  output logic          r_valid_o,
  input  logic          r_ready_i
);

  localparam int unsigned   SwLog2   = $clog2(SW);
  localparam int unsigned   IdxW     = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam logic [AW-1:0] MemBytes = AW'(NumWords * SW);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [0:0] RD_IDLE  = 1'b0;
  localparam logic [0:0] RD_BURST = 1'b1;
  localparam logic [1:0] WR_IDLE  = 2'd0;
  localparam logic [1:0] WR_DATA  = 2'd1;
  localparam logic [1:0] WR_RESP  = 2'd2;

  // Address of the beat following addr; WRAP keeps the low bits inside the (len+1)*2^size window.
  function automatic logic [AW-1:0] f_next_addr(input logic [AW-1:0] addr, input logic [2:0] size,
                                                input logic [7:0] len, input logic [1:0] burst);
    logic [AW-1:0] step;
    logic [AW-1:0] seq;
    logic [AW-1:0] wmask;
    step  = AW'(1) << size;
    seq   = (addr & ~(step - AW'(1))) + step;
    wmask = ((AW'(len) + AW'(1)) << size) - AW'(1);
    case (burst)
      BURST_FIXED: f_next_addr = addr;
      BURST_WRAP:  f_next_addr = (addr & ~wmask) | (seq & wmask);
      default:     f_next_addr = seq;
    endcase
  endfunction

  function automatic logic f_legal(input logic [AW-1:0] addr, input logic [2:0] size,
                                   input logic [7:0] len, input logic [1:0] burst);
    logic in_range;
    logic len_ok;
    in_range = (addr >= BaseAddr) && ((addr - BaseAddr) < MemBytes);
    len_ok   = (burst != BURST_WRAP) || (len == 8'd1) || (len == 8'd3) ||
               (len == 8'd7) || (len == 8'd15);
    f_legal  = in_range && (size <= 3'(SwLog2)) && (burst != BURST_RSVD) && len_ok;
  endfunction

  function automatic logic [IdxW-1:0] f_index(input logic [AW-1:0] addr);
    f_index = IdxW'((addr - BaseAddr) >> SwLog2);
  endfunction

  logic [DW-1:0] r_mem [NumWords];

  // Read engine state and registered R/AR outputs
  logic [0:0]    r_rd_state;
  logic [AW-1:0] r_rd_addr;
  logic [7:0]    r_rd_len;
  logic [2:0]    r_rd_size;
  logic [1:0]    r_rd_burst;
  logic [7:0]    r_rd_cnt;
  logic          r_ar_ready;
  logic          r_r_valid;
  logic [IW-1:0] r_r_id;
  logic [DW-1:0] r_r_data;
  logic [1:0]    r_r_resp;
  logic          r_r_last;

  logic [0:0]    w_rd_state_nxt;
  logic [AW-1:0] w_rd_addr_nxt;
  logic [7:0]    w_rd_len_nxt;
  logic [2:0]    w_rd_size_nxt;
  logic [1:0]    w_rd_burst_nxt;
  logic [7:0]    w_rd_cnt_nxt;
  logic          w_ar_ready_nxt;
  logic          w_r_valid_nxt;
  logic [IW-1:0] w_r_id_nxt;
  logic [DW-1:0] w_r_data_nxt;
  logic [1:0]    w_r_resp_nxt;
  logic          w_r_last_nxt;

  logic          w_rd_fetch;
  logic [AW-1:0] w_rd_faddr;
  logic [7:0]    w_rd_fcnt;
  logic [7:0]    w_rd_flen;
  logic [2:0]    w_rd_fsize;
  logic [1:0]    w_rd_fburst;
  logic          w_rd_flegal;
  logic [IdxW-1:0] w_rd_fidx;

  // Read next-state: a fetch loads the R output registers with the next beat.
  always_comb begin
    w_rd_state_nxt = r_rd_state;
    w_rd_addr_nxt  = r_rd_addr;
    w_rd_len_nxt   = r_rd_len;
    w_rd_size_nxt  = r_rd_size;
    w_rd_burst_nxt = r_rd_burst;
    w_rd_cnt_nxt   = r_rd_cnt;
    w_ar_ready_nxt = r_ar_ready;
    w_r_valid_nxt  = r_r_valid;
    w_r_id_nxt     = r_r_id;
    w_r_data_nxt   = r_r_data;
    w_r_resp_nxt   = r_r_resp;
    w_r_last_nxt   = r_r_last;
    w_rd_fetch     = 1'b0;
    w_rd_faddr     = f_next_addr(r_rd_addr, r_rd_size, r_rd_len, r_rd_burst);
    w_rd_fcnt      = r_rd_cnt + 8'd1;
    w_rd_flen      = r_rd_len;
    w_rd_fsize     = r_rd_size;
    w_rd_fburst    = r_rd_burst;
    case (r_rd_state)
      RD_IDLE: begin
        if (ar_valid_i) begin
          w_rd_fetch     = 1'b1;
          w_rd_faddr     = ar_addr_i;
          w_rd_fcnt      = 8'd0;
          w_rd_flen      = ar_len_i;
          w_rd_fsize     = ar_size_i;
          w_rd_fburst    = ar_burst_i;
          w_r_id_nxt     = ar_id_i;
          w_ar_ready_nxt = 1'b0;
          w_rd_state_nxt = RD_BURST;
        end
      end
      RD_BURST: begin
        if (r_ready_i) begin
          if (r_r_last) begin
            w_rd_state_nxt = RD_IDLE;
            w_ar_ready_nxt = 1'b1;
            w_r_valid_nxt  = 1'b0;
            w_r_data_nxt   = '0;
            w_r_resp_nxt   = RESP_OKAY;
            w_r_last_nxt   = 1'b0;
          end else begin
            w_rd_fetch = 1'b1;
          end
        end
      end
    endcase
    w_rd_flegal = f_legal(w_rd_faddr, w_rd_fsize, w_rd_flen, w_rd_fburst);
    w_rd_fidx   = f_index(w_rd_faddr);
    if (w_rd_fetch) begin
      w_r_valid_nxt  = 1'b1;
      w_rd_addr_nxt  = w_rd_faddr;
      w_rd_cnt_nxt   = w_rd_fcnt;
      w_rd_len_nxt   = w_rd_flen;
      w_rd_size_nxt  = w_rd_fsize;
      w_rd_burst_nxt = w_rd_fburst;
      w_r_data_nxt   = w_rd_flegal ? r_mem[w_rd_fidx] : '0;
      w_r_resp_nxt   = w_rd_flegal ? RESP_OKAY : RESP_SLVERR;
      w_r_last_nxt   = (w_rd_fcnt == w_rd_flen);
    end
  end

  always_ff @(posedge clk_i) begin : rd_regs
    if (rst_i) begin
      r_rd_state <= RD_IDLE;
      r_rd_addr  <= '0;
      r_rd_len   <= '0;
      r_rd_size  <= '0;
      r_rd_burst <= '0;
      r_rd_cnt   <= '0;
      r_ar_ready <= 1'b1;
      r_r_valid  <= 1'b0;
      r_r_id     <= '0;
      r_r_data   <= '0;
      r_r_resp   <= RESP_OKAY;
      r_r_last   <= 1'b0;
    end else begin
      r_rd_state <= w_rd_state_nxt;
      r_rd_addr  <= w_rd_addr_nxt;
      r_rd_len   <= w_rd_len_nxt;
      r_rd_size  <= w_rd_size_nxt;
      r_rd_burst <= w_rd_burst_nxt;
      r_rd_cnt   <= w_rd_cnt_nxt;
      r_ar_ready <= w_ar_ready_nxt;
      r_r_valid  <= w_r_valid_nxt;
      r_r_id     <= w_r_id_nxt;
      r_r_data   <= w_r_data_nxt;
      r_r_resp   <= w_r_resp_nxt;
      r_r_last   <= w_r_last_nxt;
    end
  end

  // Write engine state and registered AW/W/B outputs
  logic [1:0]    r_wr_state;
  logic [IW-1:0] r_wr_id;
  logic [AW-1:0] r_wr_addr;
  logic [7:0]    r_wr_len;
  logic [2:0]    r_wr_size;
  logic [1:0]    r_wr_burst;
  logic [7:0]    r_wr_cnt;
  logic          r_wr_err;
  logic          r_aw_ready;
  logic          r_w_ready;
  logic          r_b_valid;
  logic [IW-1:0] r_b_id;
  logic [1:0]    r_b_resp;

  logic [1:0]    w_wr_state_nxt;
  logic [IW-1:0] w_wr_id_nxt;
  logic [AW-1:0] w_wr_addr_nxt;
  logic [7:0]    w_wr_len_nxt;
  logic [2:0]    w_wr_size_nxt;
  logic [1:0]    w_wr_burst_nxt;
  logic [7:0]    w_wr_cnt_nxt;
  logic          w_wr_err_nxt;
  logic          w_aw_ready_nxt;
  logic          w_w_ready_nxt;
  logic          w_b_valid_nxt;
  logic [IW-1:0] w_b_id_nxt;
  logic [1:0]    w_b_resp_nxt;

  logic            w_wr_legal;
  logic            w_wr_last_beat;
  logic            w_mem_we;
  logic [IdxW-1:0] w_wr_idx;

  assign w_wr_idx = f_index(r_wr_addr);

  // Write next-state: the beat counter, not w_last_i, ends the data phase.
  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_wr_id_nxt    = r_wr_id;
    w_wr_addr_nxt  = r_wr_addr;
    w_wr_len_nxt   = r_wr_len;
    w_wr_size_nxt  = r_wr_size;
    w_wr_burst_nxt = r_wr_burst;
    w_wr_cnt_nxt   = r_wr_cnt;
    w_wr_err_nxt   = r_wr_err;
    w_aw_ready_nxt = r_aw_ready;
    w_w_ready_nxt  = r_w_ready;
    w_b_valid_nxt  = r_b_valid;
    w_b_id_nxt     = r_b_id;
    w_b_resp_nxt   = r_b_resp;
    w_mem_we       = 1'b0;
    w_wr_legal     = f_legal(r_wr_addr, r_wr_size, r_wr_len, r_wr_burst);
    w_wr_last_beat = (r_wr_cnt == r_wr_len);
    case (r_wr_state)
      WR_IDLE: begin
        if (aw_valid_i) begin
          w_wr_id_nxt    = aw_id_i;
          w_wr_addr_nxt  = aw_addr_i;
          w_wr_len_nxt   = aw_len_i;
          w_wr_size_nxt  = aw_size_i;
          w_wr_burst_nxt = aw_burst_i;
          w_wr_cnt_nxt   = 8'd0;
          w_wr_err_nxt   = |aw_atop_i;
          w_aw_ready_nxt = 1'b0;
          w_w_ready_nxt  = 1'b1;
          w_wr_state_nxt = WR_DATA;
        end
      end
      WR_DATA: begin
        if (w_valid_i) begin
          w_mem_we     = w_wr_legal && !r_wr_err;
          w_wr_err_nxt = r_wr_err || !w_wr_legal || (w_last_i != w_wr_last_beat);
          if (w_wr_last_beat) begin
            w_wr_state_nxt = WR_RESP;
            w_w_ready_nxt  = 1'b0;
            w_b_valid_nxt  = 1'b1;
            w_b_id_nxt     = r_wr_id;
            w_b_resp_nxt   = w_wr_err_nxt ? RESP_SLVERR : RESP_OKAY;
          end else begin
            w_wr_cnt_nxt  = r_wr_cnt + 8'd1;
            w_wr_addr_nxt = f_next_addr(r_wr_addr, r_wr_size, r_wr_len, r_wr_burst);
          end
        end
      end
      WR_RESP: begin
        if (b_ready_i) begin
          w_wr_state_nxt = WR_IDLE;
          w_b_valid_nxt  = 1'b0;
          w_aw_ready_nxt = 1'b1;
        end
      end
      default: begin
        w_wr_state_nxt = WR_IDLE;
        w_aw_ready_nxt = 1'b1;
        w_w_ready_nxt  = 1'b0;
        w_b_valid_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin : wr_regs
    if (rst_i) begin
      r_wr_state <= WR_IDLE;
      r_wr_id    <= '0;
      r_wr_addr  <= '0;
      r_wr_len   <= '0;
      r_wr_size  <= '0;
      r_wr_burst <= '0;
      r_wr_cnt   <= '0;
      r_wr_err   <= 1'b0;
      r_aw_ready <= 1'b1;
      r_w_ready  <= 1'b0;
      r_b_valid  <= 1'b0;
      r_b_id     <= '0;
      r_b_resp   <= RESP_OKAY;
    end else begin
      r_wr_state <= w_wr_state_nxt;
      r_wr_id    <= w_wr_id_nxt;
      r_wr_addr  <= w_wr_addr_nxt;
      r_wr_len   <= w_wr_len_nxt;
      r_wr_size  <= w_wr_size_nxt;
      r_wr_burst <= w_wr_burst_nxt;
      r_wr_cnt   <= w_wr_cnt_nxt;
      r_wr_err   <= w_wr_err_nxt;
      r_aw_ready <= w_aw_ready_nxt;
      r_w_ready  <= w_w_ready_nxt;
      r_b_valid  <= w_b_valid_nxt;
      r_b_id     <= w_b_id_nxt;
      r_b_resp   <= w_b_resp_nxt;
    end
  end

  // Byte-strobed storage; contents survive reset.
  always_ff @(posedge clk_i) begin : mem_write
    if (w_mem_we && !rst_i) begin
      for (int unsigned b = 0; b < SW; b++) begin
        if (w_strb_i[b]) r_mem[w_wr_idx][8*b +: 8] <= w_data_i[8*b +: 8];
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin : atop_check
    if (!rst_i && (r_wr_state == WR_IDLE) && aw_valid_i) begin
      assert (!aw_atop_i[5]) else $error("atomic transaction with read response is not supported");
    end
  end
`endif

  logic w_unused;
  assign w_unused = ^{ar_lock_i, ar_cache_i, ar_prot_i, ar_qos_i, ar_region_i, ar_user_i,
                      aw_lock_i, aw_cache_i, aw_prot_i, aw_qos_i, aw_region_i, aw_user_i,
                      w_user_i};

  assign ar_ready_o = r_ar_ready;
  assign aw_ready_o = r_aw_ready;
  assign w_ready_o  = r_w_ready;
  assign b_valid_o  = r_b_valid;
  assign b_id_o     = r_b_id;
  assign b_resp_o   = r_b_resp;
  assign b_user_o   = '0;
  assign r_valid_o  = r_r_valid;
  assign r_id_o     = r_r_id;
  assign r_data_o   = r_r_data;
  assign r_resp_o   = r_r_resp;
  assign r_last_o   = r_r_last;
  assign r_user_o   = '0;

endmodule
